// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 hex keypad scanner, frame debouncer and operand/operation
// entry state machine feeding the calculator core.
module keypad_entry #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DEB_SCANS = 4,
    parameter logic [15:0] ANS_CODE  = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  H,
    output logic [3:0]  V,
    output logic [15:0] SRC,
    output logic [15:0] DST,
    output logic [2:0]  ALU_OP,
    output logic        finish
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEB_SCANS);

    // Frame result kinds (stored in the upper bits of a frame result word)
    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_KEY   = 2'd1;
    localparam logic [1:0] RES_MULTI = 2'd2;

    typedef enum logic [1:0] {
        S_A  = 2'd0,
        S_B  = 2'd1,
        S_EQ = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Scan timing registers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] slot_q;
    logic [1:0]       col_q;
    logic [3:0]       v_q;
    logic             slot_end;
    logic             frame_end;
    logic [1:0]       col_nxt;

    // ------------------------------------------------------------------
    // Frame accumulation
    // ------------------------------------------------------------------
    logic [1:0] acc_cnt_q;
    logic [3:0] acc_key_q;
    logic [2:0] col_n;
    logic [3:0] col_key;
    logic [2:0] hit_sum;
    logic [1:0] tot_cnt;
    logic [3:0] tot_key;
    logic [5:0] frame_res;

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic [5:0]       prev_q;
    logic [DEB_W-1:0] run_q;
    logic             held_q;
    logic [DEB_W-1:0] run_nxt;
    logic             qualified;
    logic             key_acc;
    logic             key_rel;
    logic [3:0]       key_code;

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [2:0]  op_q;
    logic        fin_q;

    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (col_q == 2'd3);
    assign col_nxt   = col_q + 2'd1;

    // Slot counter, column index and registered active-low column drive
    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot_q <= '0;
            col_q  <= 2'd0;
            v_q    <= 4'b0111;
        end else if (slot_end) begin
            slot_q <= '0;
            col_q  <= col_nxt;
            v_q    <= ~(4'b1000 >> col_nxt);
        end else begin
            slot_q <= slot_q + DIV_W'(1);
        end
    end

    // Decode the rows pulled low in the currently driven column
    always_comb begin
        col_n   = 3'd0;
        col_key = {2'b00, col_q};
        for (int r = 0; r < 4; r++) begin
            if (!H[3-r]) begin
                col_n   = col_n + 3'd1;
                col_key = {2'(r), col_q};
            end
        end
    end

    // Merge this column into the running frame tally (saturates at two keys)
    always_comb begin
        hit_sum   = {1'b0, acc_cnt_q} + col_n;
        tot_cnt   = (hit_sum > 3'd2) ? RES_MULTI : hit_sum[1:0];
        tot_key   = (col_n != 3'd0) ? col_key : acc_key_q;
        frame_res = {tot_cnt, (tot_cnt == RES_KEY) ? tot_key : 4'h0};
    end

    // Per-frame key tally, cleared once column 3 has been folded in
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc_cnt_q <= 2'd0;
            acc_key_q <= 4'h0;
        end else if (slot_end) begin
            if (col_q == 2'd3) begin
                acc_cnt_q <= 2'd0;
                acc_key_q <= 4'h0;
            end else begin
                acc_cnt_q <= tot_cnt;
                acc_key_q <= tot_key;
            end
        end
    end

    // Run length of identical frame results and press/release qualification
    always_comb begin
        if (frame_res != prev_q) begin
            run_nxt = DEB_W'(1);
        end else if (run_q >= DEB_MAX) begin
            run_nxt = DEB_MAX;
        end else begin
            run_nxt = run_q + DEB_W'(1);
        end
        qualified = (run_nxt >= DEB_MAX);
        key_acc   = frame_end && !held_q && (tot_cnt == RES_KEY) && qualified;
        key_rel   = frame_end && held_q && (tot_cnt == RES_NONE) && qualified;
        key_code  = frame_res[3:0];
    end

    // Debouncer state: previous frame result, run length, held flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_q <= {RES_NONE, 4'h0};
            run_q  <= '0;
            held_q <= 1'b0;
        end else if (frame_end) begin
            prev_q <= frame_res;
            run_q  <= run_nxt;
            if (key_acc) begin
                held_q <= 1'b1;
            end else if (key_rel) begin
                held_q <= 1'b0;
            end
        end
    end

    // Entry FSM: digits build DST, op keys latch SRC/ALU_OP, F completes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_A;
            cnt_q   <= 3'd0;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            op_q    <= 3'd0;
            fin_q   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                S_EQ: begin
                    // Strobe has been seen by the core; switch display to ANS
                    dst_q   <= ANS_CODE;
                    cnt_q   <= 3'd0;
                    state_q <= S_A;
                end
                default: begin
                    if (key_acc) begin
                        if (key_code <= 4'd9) begin
                            if ((dst_q == ANS_CODE) || (cnt_q == 3'd0)) begin
                                dst_q <= {12'h000, key_code};
                                cnt_q <= 3'd1;
                            end else if (cnt_q < 3'd4) begin
                                dst_q <= {dst_q[11:0], key_code};
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end else if (key_code <= 4'hE) begin
                            src_q   <= dst_q;
                            op_q    <= 3'(key_code - 4'd9);
                            dst_q   <= 16'h0000;
                            cnt_q   <= 3'd0;
                            state_q <= S_B;
                        end else begin
                            if ((cnt_q == 3'd0) && (dst_q != ANS_CODE)) begin
                                dst_q <= ANS_CODE;
                            end else if (state_q == S_B) begin
                                fin_q   <= 1'b1;
                                state_q <= S_EQ;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign V      = v_q;
    assign SRC    = src_q;
    assign DST    = dst_q;
    assign ALU_OP = op_q;
    assign finish = fin_q;

endmodule
